// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: MEM/WB pipe inputs, MDU result handshake and register-file write port.
// DEPTH must match the arbiter's FIFO depth so fifo_count_o has the right width.
interface wb_arbiter_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          pipe_RegWrite_i;
    logic          pipe_MemtoReg_i;
    logic [31:0]   pipe_ALURet_i;
    logic [31:0]   pipe_ReadData_i;
    logic [4:0]    pipe_RDaddr_i;
    logic          mdu_valid_i;
    logic [31:0]   mdu_data_i;
    logic [4:0]    mdu_rd_i;
    logic          mdu_ready_o;
    logic          RegWrite_o;
    logic [4:0]    RDaddr_o;
    logic [31:0]   WriteData_o;
    logic          stall_o;
    logic [31:0]   pending_mask_o;
    logic [CW-1:0] fifo_count_o;

    modport master (
        output pipe_RegWrite_i, pipe_MemtoReg_i, pipe_ALURet_i, pipe_ReadData_i, pipe_RDaddr_i,
        output mdu_valid_i, mdu_data_i, mdu_rd_i,
        input  mdu_ready_o, RegWrite_o, RDaddr_o, WriteData_o, stall_o, pending_mask_o, fifo_count_o
    );

    modport slave (
        input  pipe_RegWrite_i, pipe_MemtoReg_i, pipe_ALURet_i, pipe_ReadData_i, pipe_RDaddr_i,
        input  mdu_valid_i, mdu_data_i, mdu_rd_i,
        output mdu_ready_o, RegWrite_o, RDaddr_o, WriteData_o, stall_o, pending_mask_o, fifo_count_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the MEM/WB pipe has priority, buffered MDU results fill free
// slots, and a starvation counter requests a one-cycle bubble when the FIFO is not draining.
module wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]   data_q [DEPTH];
    logic [4:0]    rd_q   [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    logic          pipe_busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic [31:0]   mask;

    // Slot and handshake decode
    always_comb begin
        pipe_busy  = bus.pipe_RegWrite_i && (bus.pipe_RDaddr_i != 5'd0);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(DEPTH));
        pop        = !pipe_busy && !fifo_empty;
        // x0 results complete the handshake but are never stored
        push       = bus.mdu_valid_i && !fifo_full && (bus.mdu_rd_i != 5'd0);
    end

    // Zero-latency write-port mux so forwarding timing is unaffected
    always_comb begin
        bus.RegWrite_o  = 1'b0;
        bus.RDaddr_o    = 5'd0;
        bus.WriteData_o = 32'd0;
        if (pipe_busy) begin
            bus.RegWrite_o  = 1'b1;
            bus.RDaddr_o    = bus.pipe_RDaddr_i;
            bus.WriteData_o = bus.pipe_MemtoReg_i ? bus.pipe_ReadData_i : bus.pipe_ALURet_i;
        end else if (!fifo_empty) begin
            bus.RegWrite_o  = 1'b1;
            bus.RDaddr_o    = rd_q[rd_ptr_q];
            bus.WriteData_o = data_q[rd_ptr_q];
        end
    end

    // Destinations still owed a write, for the hazard unit
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q) begin
                mask[rd_q[rd_ptr_q + AW'(i)]] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        // Starvation: bubble request is a single-cycle pulse that re-arms the counter
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if ((starve_q == SW'(STARVE_LIMIT)) && !stall_q) begin
            stall_d  = 1'b1;
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_ptr_q] <= bus.mdu_data_i;
            rd_q[wr_ptr_q]   <= bus.mdu_rd_i;
        end
    end

    assign bus.mdu_ready_o    = !fifo_full;
    assign bus.stall_o        = stall_q;
    assign bus.pending_mask_o = mask;
    assign bus.fifo_count_o   = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts every cycle's outputs,
// and a negedge monitor compares them against the DUT.
module tb_wb_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] mask;
        int          cnt;
        logic        rdy;
        logic        stall;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [4:0]  m_rd[$];
    logic [31:0] m_d[$];
    int          streak;
    bit          m_stall;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: apply one clock edge using the inputs the DUT saw during the ending cycle
    task automatic model_edge();
        bit busy, pop, ready;
        busy  = bus.pipe_RegWrite_i && (bus.pipe_RDaddr_i != 5'd0);
        pop   = !busy && (m_rd.size() > 0);
        ready = m_rd.size() < DEPTH;
        if (m_rd.size() == 0 || pop) begin
            streak  = 0;
            m_stall = 0;
        end else if (streak == LIMIT && !m_stall) begin
            streak  = 0;
            m_stall = 1;
        end else begin
            if (streak < LIMIT) streak++;
            m_stall = 0;
        end
        if (pop) begin
            void'(m_rd.pop_front());
            void'(m_d.pop_front());
        end
        if (bus.mdu_valid_i && ready && bus.mdu_rd_i != 5'd0) begin
            m_rd.push_back(bus.mdu_rd_i);
            m_d.push_back(bus.mdu_data_i);
        end
    endtask

    task automatic model_reset();
        m_rd.delete();
        m_d.delete();
        streak  = 0;
        m_stall = 0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.we = 0; e.rd = '0; e.wd = '0; e.mask = '0;
        if (bus.pipe_RegWrite_i && bus.pipe_RDaddr_i != 5'd0) begin
            e.we = 1;
            e.rd = bus.pipe_RDaddr_i;
            e.wd = bus.pipe_MemtoReg_i ? bus.pipe_ReadData_i : bus.pipe_ALURet_i;
        end else if (m_rd.size() > 0) begin
            e.we = 1;
            e.rd = m_rd[0];
            e.wd = m_d[0];
        end
        foreach (m_rd[i]) e.mask[m_rd[i]] = 1'b1;
        e.cnt   = m_rd.size();
        e.rdy   = (m_rd.size() < DEPTH);
        e.stall = m_stall;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic we, input logic mtr, input logic [31:0] alu,
                         input logic [31:0] rdat, input logic [4:0] ra,
                         input logic v, input logic [31:0] md, input logic [4:0] mr);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        bus.pipe_RegWrite_i = we;
        bus.pipe_MemtoReg_i = mtr;
        bus.pipe_ALURet_i   = alu;
        bus.pipe_ReadData_i = rdat;
        bus.pipe_RDaddr_i   = ra;
        bus.mdu_valid_i     = v;
        bus.mdu_data_i      = md;
        bus.mdu_rd_i        = mr;
        push_exp();
    endtask

    task automatic busy_cyc(input logic v, input logic [4:0] mr, input logic [31:0] md);
        cycle(1'b1, 1'b0, $urandom, $urandom, 5'd3, v, md, mr);
    endtask

    task automatic idle_cyc(input logic v, input logic [4:0] mr, input logic [31:0] md);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, v, md, mr);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("RegWrite", 32'(bus.RegWrite_o), 32'(mon_e.we));
            chk("RDaddr", 32'(bus.RDaddr_o), 32'(mon_e.rd));
            chk("WriteData", bus.WriteData_o, mon_e.wd);
            chk("pending_mask", bus.pending_mask_o, mon_e.mask);
            chk("fifo_count", 32'(bus.fifo_count_o), 32'(mon_e.cnt));
            chk("mdu_ready", 32'(bus.mdu_ready_o), 32'(mon_e.rdy));
            chk("stall", 32'(bus.stall_o), 32'(mon_e.stall));
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        model_reset();
        bus.pipe_RegWrite_i = 0; bus.pipe_MemtoReg_i = 0; bus.pipe_ALURet_i = 0;
        bus.pipe_ReadData_i = 0; bus.pipe_RDaddr_i = 0;
        bus.mdu_valid_i = 0; bus.mdu_data_i = 0; bus.mdu_rd_i = 0;

        // Reset then idle
        idle_cyc(0, 0, 0);
        idle_cyc(0, 0, 0);
        rst = 1'b0;
        idle_cyc(0, 0, 0);
        settle();
        chk("idle_regwrite", 32'(bus.RegWrite_o), 32'd0);
        chk("idle_ready", 32'(bus.mdu_ready_o), 32'd1);

        // Pipe pass-through, both mux selections, and a write to x0
        cycle(1, 1, 32'h1234, 32'hDEADBEEF, 5'd5, 0, 0, 0);
        settle();
        chk("pt_load", bus.WriteData_o, 32'hDEADBEEF);
        cycle(1, 0, 32'h1234, 32'hDEADBEEF, 5'd5, 0, 0, 0);
        settle();
        chk("pt_alu", bus.WriteData_o, 32'h1234);
        cycle(1, 0, 32'h55, 32'h66, 5'd0, 0, 0, 0);

        // MDU drain in a free slot
        idle_cyc(1, 5'd7, 32'hCAFE0001);
        idle_cyc(0, 0, 0);
        settle();
        chk("drain_mask7", bus.pending_mask_o, 32'h80);
        chk("drain_rd", 32'(bus.RDaddr_o), 32'd7);
        chk("drain_data", bus.WriteData_o, 32'hCAFE0001);
        idle_cyc(0, 0, 0);
        settle();
        chk("drain_empty", 32'(bus.fifo_count_o), 32'd0);

        // Full / backpressure
        for (int k = 1; k <= 4; k++) busy_cyc(1, 5'(k), 32'hA000_0000 + 32'(k));
        busy_cyc(1, 5'd5, 32'hA000_0005);
        settle();
        chk("full_count", 32'(bus.fifo_count_o), 32'd4);
        chk("full_ready", 32'(bus.mdu_ready_o), 32'd0);
        idle_cyc(0, 0, 0);
        settle();
        chk("full_head_rd", 32'(bus.RDaddr_o), 32'd1);
        busy_cyc(0, 0, 0);
        settle();
        chk("full_ready_back", 32'(bus.mdu_ready_o), 32'd1);
        busy_cyc(1, 5'd0, 32'hBAD0_0000);
        busy_cyc(0, 0, 0);
        settle();
        chk("rd0_not_stored", 32'(bus.fifo_count_o), 32'd3);
        repeat (4) idle_cyc(0, 0, 0);

        // Starvation bubble, then the bench honours it with a free slot
        busy_cyc(1, 5'd9, 32'h9999_0009);
        n = 0;
        while (!m_stall && n < 30) begin
            busy_cyc(0, 0, 0);
            n++;
        end
        settle();
        chk("starve_stall", 32'(bus.stall_o), 32'd1);
        idle_cyc(0, 0, 0);
        settle();
        chk("starve_drain_rd", 32'(bus.RDaddr_o), 32'd9);
        chk("starve_stall_low", 32'(bus.stall_o), 32'd0);
        idle_cyc(0, 0, 0);

        // Asynchronous reset between edges with entries queued
        for (int k = 0; k < 3; k++) busy_cyc(1, 5'(11 + k), $urandom);
        busy_cyc(0, 0, 0);
        #1;
        rst = 1'b1;
        model_reset();
        exp_q.delete();
        push_exp();
        #1;
        chk("arst_count", 32'(bus.fifo_count_o), 32'd0);
        chk("arst_mask", bus.pending_mask_o, 32'd0);
        idle_cyc(0, 0, 0);
        rst = 1'b0;
        repeat (3) idle_cyc(0, 0, 0);

        // Randomized traffic; bubble requests are usually honoured
        for (int c = 0; c < 3000; c++) begin
            logic we;
            we = ($urandom_range(9, 0) < 6);
            if (m_stall && $urandom_range(9, 0) != 0) we = 1'b0;
            cycle(we, 1'($urandom), $urandom, $urandom, 5'($urandom_range(31, 0)),
                  1'($urandom), $urandom,
                  ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)));
        end
        idle_cyc(0, 0, 0);
        settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
